palette_lut: RTL and testbench
==============================

// Module: palette_lut
// PURPOSE
//  Writable colour palette: maps a colour index to a DATA_W-bit RGB code through a
//  2-stage pipeline with valid/ready handshake, runtime-reprogrammable entries
//  and per-request brightness dimming. Generalises the fixed 8-entry read-only
//  colour converter; sits between colour-index sources and display/LED drivers.
// PARAMETERS
//  DEPTH   8   number of palette entries (>=2); ADDR_W = $clog2(DEPTH) (localparam)
//  DATA_W  24  RGB word width; must be a multiple of 3; CH_W = DATA_W/3 per channel
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  enable     in   1       global enable; low = pipeline frozen, in_ready=0
//  in_valid   in   1       lookup request valid
//  in_ready   out  1       request accepted when in_valid & in_ready
//  colour     in   ADDR_W  palette index of request
//  dim        in   2       per-request right shift applied to every channel
//  wr_en      in   1       palette write strobe
//  wr_addr    in   ADDR_W  palette write index
//  wr_data    in   DATA_W  palette write data {R,G,B}
//  out_valid  out  1       rgb holds a valid result
//  out_ready  in   1       downstream accepts result when out_valid & out_ready
//  rgb        out  DATA_W  result {R,G,B}
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, rgb=0, both stage valids=0;
//   entry i<8 = {i[2]?all1:0, i[1]?all1:0, i[0]?all1:0} per channel (000 black,
//   001 blue, 010 green, 011 cyan, 100 red, 101 magenta, 110 yellow, 111 white);
//   entries i>=8 = 0. Reset mid-operation discards in-flight requests and writes.
//  Pipeline: advance = enable & (~out_valid | out_ready); in_ready = advance.
//   Stage 1 on accept: captures mem[colour] and dim, s1_valid<=1; else if advance,
//   s1_valid<=0. Stage 2 on advance: rgb<=each CH_W channel of s1 data >> s1 dim
//   (logical, zero-fill), out_valid<=s1_valid. When !advance all stages hold.
//  Latency: result visible 2 cycles after accept edge; throughput 1/cycle when
//   out_ready held high. rgb/out_valid stable while out_valid & ~out_ready.
//  Writes: wr_en honoured every cycle independent of enable, stall and handshake.
//   wr_addr >= DEPTH (non-power-of-2 DEPTH) is ignored. colour >= DEPTH reads 0.
//  Same-cycle read/write to same index: read returns OLD contents; new value
//   visible to requests accepted on following cycles. Results already in stage 1/2
//   never change due to later writes.
//  enable low: no accepts, no advance, out_valid/rgb hold; writes still occur.
// TESTING
//  1 Reset defaults: stream colour 0..7, dim=0, out_ready=1 -> rgb 000000,0000FF,
//    00FF00,00FFFF,FF0000,FF00FF,FFFF00,FFFFFF, each 2 cycles after accept, 1/clk.
//  2 Dim: colour=7 with dim=1,2,3 -> rgb 7F7F7F, 3F3F3F, 1F1F1F.
//  3 Write then read: wr idx3=123456; same-cycle read idx3 -> 00FFFF; next-cycle
//    read idx3 -> 123456.
//  4 Backpressure: 4 back-to-back requests, out_ready low 3 cycles -> in_ready=0,
//    rgb held, no result lost/duplicated, order preserved on release.
//  5 enable low 5 cycles with wr_en to idx0=ABCDEF -> no accepts, outputs frozen;
//    after enable high, read idx0 -> ABCDEF.
//  6 rst_n pulsed with 2 requests in flight -> out_valid=0 immediately (async),
//    palette back to defaults, idx0 read -> 000000.

Source files
------------

// File: rtl/palette_lut.sv
// Writable colour palette: colour index -> {R,G,B} through a two-stage
// valid/ready pipeline with per-request brightness dimming.
module palette_lut #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 24,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] colour,
  input  logic [1:0]        dim,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rgb
);

  localparam int CH_W = DATA_W / 3;

  // Power-up palette: the three low index bits select full-scale R, G and B.
  function automatic logic [DATA_W-1:0] default_entry(input int idx);
    logic [CH_W-1:0] ones;
    logic [CH_W-1:0] zero;
    ones          = '1;
    zero          = '0;
    default_entry = '0;
    if (idx < 8) begin
      default_entry = {(idx[2] ? ones : zero),
                       (idx[1] ? ones : zero),
                       (idx[0] ? ones : zero)};
    end
  endfunction

  function automatic logic [DATA_W-1:0] dim_rgb(input logic [DATA_W-1:0] px,
                                                input logic [1:0]        sh);
    dim_rgb = '0;
    for (int c = 0; c < 3; c++) begin
      dim_rgb[c*CH_W +: CH_W] = px[c*CH_W +: CH_W] >> sh;
    end
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data;

  logic              advance;
  logic              accept;

  logic              vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic [1:0]        dim_p1_q, dim_p1_d;

  logic              vld_p2_q, vld_p2_d;
  logic [DATA_W-1:0] rgb_p2_q, rgb_p2_d;

  // Index decode by equality so addresses beyond DEPTH never match an entry.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (colour == ADDR_W'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= default_entry(i);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign advance  = enable & (~vld_p2_q | out_ready);
  assign accept   = advance & in_valid;
  assign in_ready = advance;

  // Stage 1: palette read; the register captures pre-write contents.
  assign vld_p1_d  = advance ? in_valid : vld_p1_q;
  assign data_p1_d = accept ? rd_data : data_p1_q;
  assign dim_p1_d  = accept ? dim : dim_p1_q;

  // Stage 2: per-channel dimming; rgb keeps its last result across bubbles.
  assign vld_p2_d = advance ? vld_p1_q : vld_p2_q;
  assign rgb_p2_d = (advance & vld_p1_q) ? dim_rgb(data_p1_q, dim_p1_q) : rgb_p2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      rgb_p2_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      rgb_p2_q <= rgb_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    data_p1_q <= data_p1_d;
    dim_p1_q  <= dim_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign rgb       = rgb_p2_q;

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut: directed scenarios plus randomized
// traffic scored against an array/queue reference model of the palette.
module tb_palette_lut;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] colour;
  logic [1:0]        dim;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] rgb;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  palette_lut #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .colour   (colour),
    .dim      (dim),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rgb      (rgb)
  );

  always #5 clk = ~clk;

  // Each 8-bit channel divided by 2**d, computed on whole integers.
  function automatic logic [DATA_W-1:0] shade(input logic [DATA_W-1:0] v, input int d);
    int iv, r, g, b, dv;
    iv = int'(v);
    dv = 2 ** d;
    r  = iv / 65536;
    g  = (iv / 256) % 256;
    b  = iv % 256;
    return DATA_W'(((r / dv) * 65536) + ((g / dv) * 256) + (b / dv));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 8) model_mem[i] = DATA_W'(((i / 4) % 2) * 'hFF0000 + ((i / 2) % 2) * 'h00FF00 + (i % 2) * 'h0000FF);
      else       model_mem[i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    enable    = 1'b1;
    in_valid  = 1'b0;
    colour    = '0;
    dim       = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    out_ready = 1'b1;
  endtask

  // Advance one clock; the model records accepted requests (old contents) then writes.
  task automatic tick();
    logic              acc, wr;
    logic [ADDR_W-1:0] c, wa;
    logic [1:0]        d;
    logic [DATA_W-1:0] wd;
    acc = in_valid && in_ready;
    wr  = wr_en;
    c   = colour;
    d   = dim;
    wa  = wr_addr;
    wd  = wr_data;
    @(posedge clk);
    if (rst_n) begin
      if (acc) exp_q.push_back(shade(model_mem[c], int'(d)));
      if (wr) model_mem[wa] = wd;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (rgb !== 24'h000000) begin failures++; $display("FAIL reset_rgb got=%h exp=000000", rgb); end
    #3 rst_n = 1'b1;
    model_reset();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_defaults();
    logic [DATA_W-1:0] tbl [8];
    tbl = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
            24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 8);
      colour   = ADDR_W'(k);
      dim      = 2'd0;
      #1;
      if (k < 8) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL def_in_ready k=%0d got=%b exp=1", k, in_ready); end
      end
      if (k >= 2) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL def_out_valid k=%0d got=%b exp=1", k, out_valid); end
        checks++; if (rgb !== tbl[k-2]) begin failures++; $display("FAIL def_rgb idx=%0d got=%h exp=%h", k-2, rgb, tbl[k-2]); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL def_early_valid k=%0d got=%b exp=0", k, out_valid); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_dim();
    logic [DATA_W-1:0] tbl [3];
    tbl = '{24'h7F7F7F, 24'h3F3F3F, 24'h1F1F1F};
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 3);
      colour   = 3'd7;
      dim      = 2'(k + 1);
      #1;
      if (k >= 2) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL dim_out_valid k=%0d got=%b exp=1", k, out_valid); end
        checks++; if (rgb !== tbl[k-2]) begin failures++; $display("FAIL dim_rgb dim=%0d got=%h exp=%h", k-1, rgb, tbl[k-2]); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] tbl [2];
    tbl = '{24'h00FFFF, 24'h123456};
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      in_valid = (k < 2);
      colour   = 3'd3;
      wr_en    = (k == 0);
      wr_addr  = 3'd3;
      wr_data  = 24'h123456;
      #1;
      if (k >= 2) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL wr_out_valid k=%0d got=%b exp=1", k, out_valid); end
        checks++; if (rgb !== tbl[k-2]) begin failures++; $display("FAIL wr_rgb k=%0d got=%h exp=%h", k, rgb, tbl[k-2]); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int                sent, got;
    bit                stalled;
    logic [DATA_W-1:0] held;
    sent = 0; got = 0; stalled = 0; held = '0;
    idle_inputs();
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      in_valid  = (sent < 4);
      colour    = ADDR_W'($urandom);
      dim       = 2'($urandom);
      out_ready = !(k >= 2 && k < 5);
      #1;
      checks++; if (in_ready !== (!out_valid || out_ready)) begin failures++; $display("FAIL bp_in_ready k=%0d got=%b", k, in_ready); end
      if (k >= 2 && k < 5) begin
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall k=%0d valid=%b ready=%b exp valid=1 ready=0", k, out_valid, in_ready); end
      end
      if (out_valid && !out_ready) begin
        if (stalled) begin
          checks++; if (rgb !== held) begin failures++; $display("FAIL bp_hold k=%0d got=%h exp=%h", k, rgb, held); end
        end
        held = rgb;
        stalled = 1;
      end else begin
        stalled = 0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra_result got=%h exp=none", rgb); end
        else begin
          if (rgb !== exp_q[0]) begin failures++; $display("FAIL bp_order got=%h exp=%h", rgb, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    checks++; if (got !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL bp_leftover got=%0d exp=0", exp_q.size()); end
    idle_inputs();
  endtask

  task automatic test_enable();
    idle_inputs();
    in_valid = 1'b1;
    colour   = 3'd5;
    #1;
    tick();
    enable   = 1'b0;
    colour   = 3'd2;
    for (int j = 0; j < 5; j++) begin
      wr_en   = (j == 0);
      wr_addr = 3'd0;
      wr_data = 24'hABCDEF;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL en_in_ready j=%0d got=%b exp=0", j, in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL en_frozen j=%0d got=%b exp=0", j, out_valid); end
      tick();
    end
    wr_en  = 1'b0;
    enable = 1'b1;
    colour = 3'd0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL en_resume_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || rgb !== 24'hFF00FF) begin failures++; $display("FAIL en_first valid=%b rgb=%h exp valid=1 rgb=ff00ff", out_valid, rgb); end
    checks++; if (exp_q.size() == 0 || rgb !== exp_q[0]) begin failures++; $display("FAIL en_first_model got=%h", rgb); end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    tick();
    #1;
    checks++; if (out_valid !== 1'b1 || rgb !== 24'hABCDEF) begin failures++; $display("FAIL en_written valid=%b rgb=%h exp valid=1 rgb=abcdef", out_valid, rgb); end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    in_valid = 1'b1;
    colour   = 3'd0;
    #1;
    tick();
    colour = 3'd3;
    #1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    checks++; if (rgb !== 24'h000000) begin failures++; $display("FAIL rst_async_rgb got=%h exp=000000", rgb); end
    #1 rst_n = 1'b1;
    model_reset();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_discard got=%b exp=0", out_valid); end
    in_valid = 1'b1;
    colour   = 3'd0;
    #1;
    tick();
    colour = 3'd3;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || rgb !== 24'h000000) begin failures++; $display("FAIL rst_idx0 valid=%b rgb=%h exp valid=1 rgb=000000", out_valid, rgb); end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    tick();
    #1;
    checks++; if (out_valid !== 1'b1 || rgb !== 24'h00FFFF) begin failures++; $display("FAIL rst_idx3 valid=%b rgb=%h exp valid=1 rgb=00ffff", out_valid, rgb); end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    idle_inputs();
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      enable    = ($urandom_range(0, 9) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      colour    = ADDR_W'($urandom);
      dim       = 2'($urandom);
      wr_en     = ($urandom_range(0, 4) == 0);
      wr_addr   = ADDR_W'($urandom);
      wr_data   = DATA_W'($urandom);
      out_ready = enable ? ($urandom_range(0, 3) != 0) : 1'b0;
      #1;
      checks++; if (in_ready !== (enable && (!out_valid || out_ready))) begin failures++; $display("FAIL rnd_in_ready n=%0d got=%b", n, in_ready); end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rnd_extra_result n=%0d got=%h exp=none", n, rgb); end
        else begin
          if (rgb !== exp_q[0]) begin failures++; $display("FAIL rnd_rgb n=%0d got=%h exp=%h", n, rgb, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      tick();
    end
    idle_inputs();
    for (int j = 0; j < 6; j++) begin
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rnd_drain_extra got=%h exp=none", rgb); end
        else begin
          if (rgb !== exp_q[0]) begin failures++; $display("FAIL rnd_drain_rgb got=%h exp=%h", rgb, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      tick();
    end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rnd_lost got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_dim();
    test_write_read();
    test_backpressure();
    test_enable();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached=%0t limit=200000", $time);
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
